// File: rtl/rx_pkg.sv
// Shared definitions for the receive frame checker: FSM states, parity-type
// encoding and legal parameter ranges.
package rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HOLD  = 2'd2
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;
    localparam int STOP_W_MIN = 1;
    localparam int STOP_W_MAX = 2;

endpackage

// File: rtl/rx_parity_calc.sv
// Combinational parity checker: flags a mismatch between the data word,
// the received parity bit and the configured parity type.
module rx_parity_calc
    import rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par_typ,
    input  logic              par_bit,
    output logic              par_err
);

    function automatic logic odd_ones(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Even type expects an even total of ones including the parity bit.
    assign par_err = odd_ones(data) ^ par_bit ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/rx_frame_checker.sv
// Receive frame checker: validates parity/stop/glitch of a deserialised frame,
// holds clean frames for a ready/valid consumer. Optional counters: RX_ERR_CNT_EN.
module rx_frame_checker
    import rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STOP_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              frame_done,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              par_bit,
    input  logic [STOP_W-1:0] stop_bits,
    input  logic              strt_glitch,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              out_ready,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              PAR_ERR,
    output logic              STP_ERR,
    output logic              GLT_ERR,
    output logic              OVR_ERR,
    output logic [CNT_W-1:0]  par_cnt,
    output logic [CNT_W-1:0]  stp_cnt,
    output logic [CNT_W-1:0]  ovr_cnt
);

    rx_state_e         state_r;
    rx_state_e         state_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic              par_bit_r;
    logic [STOP_W-1:0] stop_r;
    logic              glt_r;
    logic              par_en_r;
    logic              par_typ_r;

    logic              calc_err_s;
    logic              par_err_s;
    logic              stp_err_s;
    logic              latch_s;
    logic              load_out_s;
    logic              drop_valid_s;
    logic              par_pulse_s;
    logic              stp_pulse_s;
    logic              glt_pulse_s;
    logic              ovr_pulse_s;

    rx_parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity (
        .data    (data_r),
        .par_typ (par_typ_r),
        .par_bit (par_bit_r),
        .par_err (calc_err_s)
    );

    assign par_err_s = par_en_r & calc_err_s;
    assign stp_err_s = ~(&stop_r);

    // Next-state and per-cycle action decode.
    always_comb begin
        state_nxt_s  = state_r;
        latch_s      = 1'b0;
        load_out_s   = 1'b0;
        drop_valid_s = 1'b0;
        par_pulse_s  = 1'b0;
        stp_pulse_s  = 1'b0;
        glt_pulse_s  = 1'b0;
        ovr_pulse_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_done) begin
                    latch_s     = 1'b1;
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // A frame arriving while the previous one is still being checked is lost.
                ovr_pulse_s = frame_done;
                if (glt_r) begin
                    glt_pulse_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (par_err_s || stp_err_s) begin
                    par_pulse_s = par_err_s;
                    stp_pulse_s = stp_err_s;
                    state_nxt_s = ST_IDLE;
                end else begin
                    load_out_s  = 1'b1;
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    drop_valid_s = 1'b1;
                    if (frame_done) begin
                        latch_s     = 1'b1;
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    ovr_pulse_s = frame_done;
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame field capture at frame acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_r    <= {DATA_W{1'b0}};
            par_bit_r <= 1'b0;
            stop_r    <= {STOP_W{1'b0}};
            glt_r     <= 1'b0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else if (latch_s) begin
            data_r    <= P_DATA;
            par_bit_r <= par_bit;
            stop_r    <= stop_bits;
            glt_r     <= strt_glitch;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
        end else begin
            data_r    <= data_r;
            par_bit_r <= par_bit_r;
            stop_r    <= stop_r;
            glt_r     <= glt_r;
            par_en_r  <= par_en_r;
            par_typ_r <= par_typ_r;
        end
    end

    // Output data/valid register; data keeps its last value after transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_data  <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
        end else if (load_out_s) begin
            out_data  <= data_r;
            out_valid <= 1'b1;
        end else if (drop_valid_s) begin
            out_data  <= out_data;
            out_valid <= 1'b0;
        end else begin
            out_data  <= out_data;
            out_valid <= out_valid;
        end
    end

    // One-cycle error pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PAR_ERR <= 1'b0;
            STP_ERR <= 1'b0;
            GLT_ERR <= 1'b0;
            OVR_ERR <= 1'b0;
        end else begin
            PAR_ERR <= par_pulse_s;
            STP_ERR <= stp_pulse_s;
            GLT_ERR <= glt_pulse_s;
            OVR_ERR <= ovr_pulse_s;
        end
    end

`ifdef RX_ERR_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W-1:0] res;
        if (inc && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Saturating error counters; counts track the pulse registers edge for edge.
    always_ff @(posedge CLK) begin
        if (RST || clr_cnt) begin
            par_cnt <= {CNT_W{1'b0}};
            stp_cnt <= {CNT_W{1'b0}};
            ovr_cnt <= {CNT_W{1'b0}};
        end else begin
            par_cnt <= sat_inc(par_cnt, par_pulse_s);
            stp_cnt <= sat_inc(stp_cnt, stp_pulse_s);
            ovr_cnt <= sat_inc(ovr_cnt, ovr_pulse_s);
        end
    end
`else
    logic unused_clr_cnt_s;

    assign unused_clr_cnt_s = clr_cnt;
    assign par_cnt          = {CNT_W{1'b0}};
    assign stp_cnt          = {CNT_W{1'b0}};
    assign ovr_cnt          = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed plus randomized bench for rx_frame_checker with a frame-level reference model.
module tb_rx_frame_checker;

    localparam int DW   = 8;
    localparam int SW   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef RX_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          frame_done = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          par_bit = 1'b0;
    logic [SW-1:0] stop_bits = '1;
    logic          strt_glitch = 1'b0;
    logic          PAR_EN = 1'b1;
    logic          PAR_TYP = 1'b0;
    logic          out_ready = 1'b1;
    logic          clr_cnt = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          PAR_ERR, STP_ERR, GLT_ERR, OVR_ERR;
    logic [CW-1:0] par_cnt, stp_cnt, ovr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one frame awaiting its verdict, one frame awaiting pickup.
    bit            m_pend_v;
    logic [DW-1:0] m_pend_d;
    bit            m_pend_p, m_pend_g, m_pend_en, m_pend_typ;
    logic [SW-1:0] m_pend_s;
    bit            m_held_v;
    logic [DW-1:0] m_held_d;
    bit            m_par, m_stp, m_glt, m_ovr;
    int            m_par_c, m_stp_c, m_ovr_c;

    rx_frame_checker #(
        .DATA_W (DW),
        .STOP_W (SW),
        .CNT_W  (CW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_done  (frame_done),
        .P_DATA      (P_DATA),
        .par_bit     (par_bit),
        .stop_bits   (stop_bits),
        .strt_glitch (strt_glitch),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .out_ready   (out_ready),
        .clr_cnt     (clr_cnt),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .PAR_ERR     (PAR_ERR),
        .STP_ERR     (STP_ERR),
        .GLT_ERR     (GLT_ERR),
        .OVR_ERR     (OVR_ERR),
        .par_cnt     (par_cnt),
        .stp_cnt     (stp_cnt),
        .ovr_cnt     (ovr_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic int bump(input int c, input bit hit);
        if (!CNT_ON) return 0;
        if (hit && c < CMAX) return c + 1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take_frame();
        m_pend_v   = 1'b1;
        m_pend_d   = P_DATA;
        m_pend_p   = par_bit;
        m_pend_s   = stop_bits;
        m_pend_g   = strt_glitch;
        m_pend_en  = PAR_EN;
        m_pend_typ = PAR_TYP;
    endtask

    task automatic model_edge();
        bit pe, se;
        if (RST) begin
            m_pend_v = 0; m_held_v = 0; m_held_d = '0;
            m_par = 0; m_stp = 0; m_glt = 0; m_ovr = 0;
            m_par_c = 0; m_stp_c = 0; m_ovr_c = 0;
        end else begin
            m_par = 0; m_stp = 0; m_glt = 0; m_ovr = 0;
            if (m_pend_v) begin
                pe = m_pend_en && ((($countones(m_pend_d) + int'(m_pend_p) + int'(m_pend_typ)) % 2) == 1);
                se = (m_pend_s != {SW{1'b1}});
                if (m_pend_g) m_glt = 1;
                else begin m_par = pe; m_stp = se; end
                if (!m_pend_g && !pe && !se) begin
                    m_held_v = 1;
                    m_held_d = m_pend_d;
                end
                m_pend_v = 0;
                if (frame_done) m_ovr = 1;
            end else if (m_held_v) begin
                if (out_ready) begin
                    m_held_v = 0;
                    if (frame_done) take_frame();
                end else if (frame_done) m_ovr = 1;
            end else if (frame_done) begin
                take_frame();
            end
            if (clr_cnt && CNT_ON) begin
                m_par_c = 0; m_stp_c = 0; m_ovr_c = 0;
            end else begin
                m_par_c = bump(m_par_c, m_par);
                m_stp_c = bump(m_stp_c, m_stp);
                m_ovr_c = bump(m_ovr_c, m_ovr);
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_held_v));
        if (m_held_v) chk("out_data", 32'(out_data), 32'(m_held_d));
        chk("PAR_ERR", 32'(PAR_ERR), 32'(m_par));
        chk("STP_ERR", 32'(STP_ERR), 32'(m_stp));
        chk("GLT_ERR", 32'(GLT_ERR), 32'(m_glt));
        chk("OVR_ERR", 32'(OVR_ERR), 32'(m_ovr));
        chk("par_cnt", 32'(par_cnt), 32'(m_par_c));
        chk("stp_cnt", 32'(stp_cnt), 32'(m_stp_c));
        chk("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr_c));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic p, input logic [SW-1:0] s,
                        input logic g, input logic en);
        P_DATA = d; par_bit = p; stop_bits = s; strt_glitch = g; PAR_EN = en; PAR_TYP = 1'b0;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    initial begin
        // Reset, including a frame_done coincident with reset.
        RST = 1'b1; frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        step();
        chk("rst_out_data", 32'(out_data), 32'h0);
        RST = 1'b0;
        step();
        chk("rst_fd_ignored", 32'(out_valid), 32'h0);

        // Clean frame: valid two cycles after frame_done.
        out_ready = 1'b1;
        send(8'hA5, 1'b0, 2'b11, 1'b0, 1'b1);
        chk("clean_not_yet", 32'(out_valid), 32'h0);
        step();
        chk("clean_valid", 32'(out_valid), 32'h1);
        chk("clean_data", 32'(out_data), 32'hA5);
        step();
        chk("clean_taken", 32'(out_valid), 32'h0);

        // Parity error, then the same frame with parity disabled.
        send(8'hA5, 1'b1, 2'b11, 1'b0, 1'b1);
        step();
        chk("par_pulse", 32'(PAR_ERR), 32'h1);
        step();
        chk("par_one_cycle", 32'(PAR_ERR), 32'h0);
        send(8'hA5, 1'b1, 2'b11, 1'b0, 1'b0);
        step();
        chk("par_dis_valid", 32'(out_valid), 32'h1);
        step();

        // Glitch suppresses stop error; without glitch the stop error shows.
        send(8'h5A, 1'b0, 2'b10, 1'b1, 1'b1);
        step();
        chk("glt_pulse", 32'(GLT_ERR), 32'h1);
        chk("glt_no_stp", 32'(STP_ERR), 32'h0);
        send(8'h5A, 1'b0, 2'b10, 1'b0, 1'b1);
        step();
        chk("stp_pulse", 32'(STP_ERR), 32'h1);
        step();

        // Overrun in HOLD, then transfer with back-to-back frame.
        out_ready = 1'b0;
        send(8'h11, 1'b0, 2'b11, 1'b0, 1'b1);
        step(); step();
        send(8'h22, 1'b0, 2'b11, 1'b0, 1'b1);
        chk("ovr_pulse", 32'(OVR_ERR), 32'h1);
        chk("ovr_keep", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        send(8'h33, 1'b0, 2'b11, 1'b0, 1'b1);
        chk("b2b_no_ovr", 32'(OVR_ERR), 32'h0);
        step();
        chk("b2b_data", 32'(out_data), 32'h33);
        step();

        // Counter saturation and clear priority.
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'h01, 1'b0, 2'b11, 1'b0, 1'b1);
            step();
        end
        chk("par_cnt_sat", 32'(par_cnt), CNT_ON ? 32'd3 : 32'd0);
        send(8'h01, 1'b0, 2'b11, 1'b0, 1'b1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_wins", 32'(par_cnt), 32'h0);

        // Reset while holding a frame.
        out_ready = 1'b0;
        send(8'h77, 1'b0, 2'b11, 1'b0, 1'b1);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_hold", 32'(out_valid), 32'h0);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            frame_done  = ($urandom_range(0, 2) == 0);
            P_DATA      = DW'($urandom);
            par_bit     = 1'($urandom);
            stop_bits   = ($urandom_range(0, 3) == 0) ? SW'($urandom) : {SW{1'b1}};
            strt_glitch = ($urandom_range(0, 7) == 0);
            PAR_EN      = 1'($urandom);
            PAR_TYP     = 1'($urandom);
            out_ready   = 1'($urandom);
            clr_cnt     = ($urandom_range(0, 40) == 0);
            RST         = ($urandom_range(0, 80) == 0);
            step();
        end
        RST = 1'b0; frame_done = 1'b0; clr_cnt = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
